// File: rtl/buf_pingpong_ctrl.sv
// buf_pingpong_ctrl
// Write-side and bank-ownership controller for a double-banked (ping-pong)
// simple-dual-port buffer. The loader fills one bank while the executor reads
// the other.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   cfg_ld_len               tile length minus one (captured at the first beat of a tile)
//   ld_valid/ld_ready/ld_data  loader beat stream
//   buf_ld_wr_en/sel/addr/data registered buffer write port (1-cycle latency)
//   ex_tile_valid, buf_ex_sel  executor view: selected bank and whether it holds a tile
//   ex_tile_done             one-cycle pulse, executor finished the current tile
//   bank_full                per-bank full flags
//   tiles_loaded/executed    wrapping status counters
//   err_underflow            sticky: ex_tile_done seen while the exec bank was empty
module buf_pingpong_ctrl #(
    parameter int unsigned BUF_LD_ADDR_WIDTH = 10,
    parameter int unsigned BUF_LD_DATA_WIDTH = 8,
    parameter int unsigned TILE_CNT_WIDTH    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUF_LD_ADDR_WIDTH-1:0] cfg_ld_len,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [BUF_LD_DATA_WIDTH-1:0] ld_data,
    output logic                         buf_ld_wr_en,
    output logic                         buf_ld_sel,
    output logic [BUF_LD_ADDR_WIDTH-1:0] buf_ld_addr,
    output logic [BUF_LD_DATA_WIDTH-1:0] buf_ld_data,
    output logic                         ex_tile_valid,
    output logic                         buf_ex_sel,
    input  logic                         ex_tile_done,
    output logic [1:0]                   bank_full,
    output logic [TILE_CNT_WIDTH-1:0]    tiles_loaded,
    output logic [TILE_CNT_WIDTH-1:0]    tiles_executed,
    output logic                         err_underflow
);

    localparam int unsigned AW = BUF_LD_ADDR_WIDTH;
    localparam int unsigned CW = TILE_CNT_WIDTH;

    logic          lp;          // bank being loaded
    logic          ep;          // bank owned by the executor
    logic [AW-1:0] wcnt;        // word index within the current tile
    logic [AW-1:0] len_r;       // tile length minus one, held for the whole tile
    logic [1:0]    full;
    logic          pend_set;    // final write of a tile is on the port this cycle
    logic          pend_bank;

    logic          accept;
    logic          last_beat;
    logic          done_ok;
    logic [AW-1:0] eff_len;
    logic [1:0]    full_nxt;

    // Handshake and tile-boundary decode from registered state.
    always_comb begin
        ld_ready  = !full[lp] && !rst;
        accept    = ld_valid && ld_ready;
        // The first beat of a tile sees cfg_ld_len directly; len_r is not yet loaded.
        eff_len   = (wcnt == '0) ? cfg_ld_len : len_r;
        last_beat = accept && (wcnt == eff_len);
        done_ok   = ex_tile_done && full[ep];
    end

    // Full flags: the set is delayed one cycle so it lands with the edge that
    // commits the final write. Set and clear never target the same bank.
    always_comb begin
        full_nxt = full;
        if (done_ok) begin
            full_nxt[ep] = 1'b0;
        end
        if (pend_set) begin
            full_nxt[pend_bank] = 1'b1;
        end
    end

    assign buf_ex_sel    = ep;
    assign ex_tile_valid = full[ep];
    assign bank_full     = full;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lp             <= 1'b0;
            ep             <= 1'b0;
            wcnt           <= '0;
            len_r          <= '0;
            full           <= 2'b00;
            pend_set       <= 1'b0;
            pend_bank      <= 1'b0;
            tiles_loaded   <= '0;
            tiles_executed <= '0;
            err_underflow  <= 1'b0;
            buf_ld_wr_en   <= 1'b0;
            buf_ld_sel     <= 1'b0;
            buf_ld_addr    <= '0;
            buf_ld_data    <= '0;
        end else begin
            buf_ld_wr_en <= accept;
            pend_set     <= last_beat;
            pend_bank    <= lp;
            full         <= full_nxt;

            if (accept) begin
                buf_ld_sel  <= lp;
                buf_ld_addr <= wcnt;
                buf_ld_data <= ld_data;
                if (wcnt == '0) begin
                    len_r <= cfg_ld_len;
                end
                if (last_beat) begin
                    wcnt <= '0;
                    lp   <= ~lp;
                end else begin
                    wcnt <= wcnt + AW'(1);
                end
            end

            if (pend_set) begin
                tiles_loaded <= tiles_loaded + CW'(1);
            end

            if (done_ok) begin
                ep             <= ~ep;
                tiles_executed <= tiles_executed + CW'(1);
            end else if (ex_tile_done) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_buf_pingpong_ctrl.sv
// tb_buf_pingpong_ctrl
// Directed scenarios followed by a randomized phase. A tile-level reference
// model (bank occupancy, word index, tile-completion events scheduled in time)
// predicts every output each cycle.
module tb_buf_pingpong_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst;
    logic [AW-1:0] cfg_ld_len;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          buf_ld_wr_en;
    logic          buf_ld_sel;
    logic [AW-1:0] buf_ld_addr;
    logic [DW-1:0] buf_ld_data;
    logic          ex_tile_valid;
    logic          buf_ex_sel;
    logic          ex_tile_done;
    logic [1:0]    bank_full;
    logic [CW-1:0] tiles_loaded;
    logic [CW-1:0] tiles_executed;
    logic          err_underflow;

    buf_pingpong_ctrl #(
        .BUF_LD_ADDR_WIDTH(AW),
        .BUF_LD_DATA_WIDTH(DW),
        .TILE_CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_ld_len    (cfg_ld_len),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_data       (ld_data),
        .buf_ld_wr_en  (buf_ld_wr_en),
        .buf_ld_sel    (buf_ld_sel),
        .buf_ld_addr   (buf_ld_addr),
        .buf_ld_data   (buf_ld_data),
        .ex_tile_valid (ex_tile_valid),
        .buf_ex_sel    (buf_ex_sel),
        .ex_tile_done  (ex_tile_done),
        .bank_full     (bank_full),
        .tiles_loaded  (tiles_loaded),
        .tiles_executed(tiles_executed),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_lp, m_ep, m_idx, m_len, m_loaded, m_exec, m_err;
    int m_full [2];
    int m_wr_en, m_sel, m_addr, m_data;
    int cyc;
    int fin_bank_q [$];
    int fin_due_q  [$];
    bit last_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lp = 0; m_ep = 0; m_idx = 0; m_len = 0;
        m_loaded = 0; m_exec = 0; m_err = 0;
        m_full[0] = 0; m_full[1] = 0;
        m_wr_en = 0; m_sel = 0; m_addr = 0; m_data = 0;
        fin_bank_q.delete();
        fin_due_q.delete();
    endtask

    // One clock cycle: drive inputs, check all outputs against the model, advance the model.
    task automatic do_cycle(input logic r, input logic v, input logic [DW-1:0] d,
                            input logic [AW-1:0] len, input logic dn);
        bit exp_ready;
        @(negedge clk);
        rst = r; ld_valid = v; ld_data = d; cfg_ld_len = len; ex_tile_done = dn;
        #1;
        exp_ready = (r == 1'b0) && (m_full[m_lp] == 0);
        chk("ld_ready", 32'(ld_ready), 32'(exp_ready));
        chk("wr_en", 32'(buf_ld_wr_en), 32'(m_wr_en));
        if (m_wr_en != 0) begin
            chk("wr_sel", 32'(buf_ld_sel), 32'(m_sel));
            chk("wr_addr", 32'(buf_ld_addr), 32'(m_addr));
            chk("wr_data", 32'(buf_ld_data), 32'(m_data));
        end
        chk("ex_tile_valid", 32'(ex_tile_valid), 32'(m_full[m_ep]));
        chk("buf_ex_sel", 32'(buf_ex_sel), 32'(m_ep));
        chk("bank_full", 32'(bank_full), 32'(m_full[1] * 2 + m_full[0]));
        chk("tiles_loaded", 32'(tiles_loaded), 32'(16'(m_loaded)));
        chk("tiles_executed", 32'(tiles_executed), 32'(16'(m_exec)));
        chk("err_underflow", 32'(err_underflow), 32'(m_err));

        last_acc = exp_ready && v;
        if (r) begin
            model_reset();
        end else begin
            m_wr_en = int'(last_acc);
            if (last_acc) begin
                m_sel  = m_lp;
                m_addr = m_idx;
                m_data = int'(d);
                if (m_idx == 0) m_len = int'(len) + 1;
                m_idx++;
                if (m_idx == m_len) begin
                    // Tile becomes visible to the executor two cycles after its last beat.
                    fin_bank_q.push_back(m_lp);
                    fin_due_q.push_back(cyc + 2);
                    m_idx = 0;
                    m_lp  = 1 - m_lp;
                end
            end
            if (dn) begin
                if (m_full[m_ep] != 0) begin
                    m_full[m_ep] = 0;
                    m_ep = 1 - m_ep;
                    m_exec++;
                end else begin
                    m_err = 1;
                end
            end
            while (fin_due_q.size() > 0 && fin_due_q[0] == cyc + 1) begin
                m_full[fin_bank_q[0]] = 1;
                m_loaded++;
                void'(fin_bank_q.pop_front());
                void'(fin_due_q.pop_front());
            end
        end
        cyc++;
    endtask

    initial begin
        logic [DW-1:0] cur_data;
        logic          rr;
        logic          vv;
        logic          dd;
        logic [AW-1:0] ll;

        rst = 1'b1; ld_valid = 1'b1; ld_data = 8'h55; cfg_ld_len = 10'd3; ex_tile_done = 1'b0;
        cyc = 0;
        model_reset();
        @(posedge clk);

        // Reset held with ld_valid high, then release
        do_cycle(1'b1, 1'b1, 8'h55, 10'd3, 1'b0);
        do_cycle(1'b1, 1'b1, 8'h55, 10'd3, 1'b0);
        chk("rst_ready_low", 32'(ld_ready), 32'd0);
        chk("rst_wr_en_low", 32'(buf_ld_wr_en), 32'd0);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd3, 1'b0);
        chk("rel_ready", 32'(ld_ready), 32'd1);

        // Single 4-word tile
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 8'(8'hA0 + i), 10'd3, 1'b0);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd3, 1'b0);
        chk("st_last_addr", 32'(buf_ld_addr), 32'd3);
        chk("st_last_data", 32'(buf_ld_data), 32'hA3);
        chk("st_not_yet_valid", 32'(ex_tile_valid), 32'd0);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd3, 1'b0);
        chk("st_ex_valid", 32'(ex_tile_valid), 32'd1);
        chk("st_ex_sel", 32'(buf_ex_sel), 32'd0);
        chk("st_loaded", 32'(tiles_loaded), 32'd1);

        // Backpressure: both banks fill, 9th beat stalls until a bank frees
        do_cycle(1'b1, 1'b0, 8'h00, 10'd3, 1'b0);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, 1'b1, 8'(i + 1), 10'd3, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h99, 10'd3, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h99, 10'd3, 1'b0);
        chk("bp_full", 32'(bank_full), 32'd3);
        chk("bp_ready", 32'(ld_ready), 32'd0);
        do_cycle(1'b0, 1'b1, 8'h99, 10'd3, 1'b1);
        do_cycle(1'b0, 1'b1, 8'h99, 10'd3, 1'b0);
        chk("bp_full_after", 32'(bank_full), 32'd2);
        chk("bp_ex_sel", 32'(buf_ex_sel), 32'd1);
        chk("bp_ready_back", 32'(ld_ready), 32'd1);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd3, 1'b0);
        chk("bp_9th_en", 32'(buf_ld_wr_en), 32'd1);
        chk("bp_9th_sel", 32'(buf_ld_sel), 32'd0);
        chk("bp_9th_addr", 32'(buf_ld_addr), 32'd0);
        chk("bp_9th_data", 32'(buf_ld_data), 32'h99);

        // Underflow: done with nothing full
        do_cycle(1'b1, 1'b0, 8'h00, 10'd3, 1'b0);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd3, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd3, 1'b0);
        chk("uf_err", 32'(err_underflow), 32'd1);
        chk("uf_full", 32'(bank_full), 32'd0);
        chk("uf_ex_sel", 32'(buf_ex_sel), 32'd0);
        chk("uf_exec", 32'(tiles_executed), 32'd0);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd3, 1'b0);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd3, 1'b0);
        chk("uf_sticky", 32'(err_underflow), 32'd1);

        // Simultaneous: last beat of bank 1 with done for bank 0
        do_cycle(1'b1, 1'b0, 8'h00, 10'd1, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h10, 10'd1, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h11, 10'd1, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h12, 10'd1, 1'b0);
        do_cycle(1'b0, 1'b1, 8'h13, 10'd1, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd1, 1'b0);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd1, 1'b0);
        chk("sim_full", 32'(bank_full), 32'd2);
        chk("sim_ex_sel", 32'(buf_ex_sel), 32'd1);
        chk("sim_loaded", 32'(tiles_loaded), 32'd2);
        chk("sim_exec", 32'(tiles_executed), 32'd1);

        // Reset mid-tile: partial tile discarded, restart at bank 0 address 0
        do_cycle(1'b1, 1'b0, 8'h00, 10'd7, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 8'(8'h20 + i), 10'd7, 1'b0);
        do_cycle(1'b1, 1'b0, 8'h00, 10'd7, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 1'b1, 8'(8'h30 + i), 10'd7, 1'b0);
            if (i == 1) begin
                chk("mt_first_sel", 32'(buf_ld_sel), 32'd0);
                chk("mt_first_addr", 32'(buf_ld_addr), 32'd0);
                chk("mt_first_data", 32'(buf_ld_data), 32'h30);
            end
        end
        do_cycle(1'b0, 1'b0, 8'h00, 10'd7, 1'b0);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd7, 1'b0);
        chk("mt_full", 32'(bank_full), 32'd1);

        // Maximum-length tile (full address range), cfg change mid-tile ignored
        do_cycle(1'b1, 1'b0, 8'h00, 10'h3FF, 1'b0);
        for (int i = 0; i < 1024; i++)
            do_cycle(1'b0, 1'b1, 8'($urandom), (i == 0) ? 10'h3FF : 10'(i % 5), 1'b0);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd2, 1'b0);
        chk("max_last_addr", 32'(buf_ld_addr), 32'h3FF);
        do_cycle(1'b0, 1'b0, 8'h00, 10'd2, 1'b0);
        chk("max_full", 32'(bank_full), 32'd1);
        chk("max_loaded", 32'(tiles_loaded), 32'd1);

        // Randomized traffic; loader holds its data until accepted
        do_cycle(1'b1, 1'b0, 8'h00, 10'd0, 1'b0);
        cur_data = 8'($urandom);
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 299) == 0);
            vv = ($urandom_range(0, 3) != 0);
            dd = ($urandom_range(0, 3) == 0);
            ll = 10'($urandom_range(0, 5));
            do_cycle(rr, vv, cur_data, ll, dd);
            if (last_acc) cur_data = 8'($urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/buf_pingpong_ctrl.md
Name: buf_pingpong_ctrl

Overview:
- Controls one double-banked (ping-pong) simple-dual-port activation/weight buffer.
- Accepts a word stream from the loader (valid/ready) and generates the buffer write-port signals: write enable, bank select, address and data.
- Tracks which bank holds a complete tile, hands full banks to the executor through the read-bank select, and frees each bank when the executor signals tile completion.
- Loading of one bank overlaps execution from the other.

Parameters:
- BUF_LD_ADDR_WIDTH, 10: per-bank write address width; a tile holds at most 2^BUF_LD_ADDR_WIDTH words.
- BUF_LD_DATA_WIDTH, 8: write data width.
- TILE_CNT_WIDTH, 16: width of the tile status counters.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- cfg_ld_len  in  BUF_LD_ADDR_WIDTH  tile length minus one, in words.
- ld_valid  in  1  loader beat valid.
- ld_ready  out  1  controller can accept a beat.
- ld_data  in  BUF_LD_DATA_WIDTH  loader beat data.
- buf_ld_wr_en  out  1  buffer write enable.
- buf_ld_sel  out  1  write bank select.
- buf_ld_addr  out  BUF_LD_ADDR_WIDTH  write address within the bank.
- buf_ld_data  out  BUF_LD_DATA_WIDTH  write data.
- ex_tile_valid  out  1  the bank selected by buf_ex_sel holds a complete tile.
- buf_ex_sel  out  1  read bank select for the executor.
- ex_tile_done  in  1  one-cycle pulse: executor has finished the current tile.
- bank_full  out  2  per-bank full flags.
- tiles_loaded  out  TILE_CNT_WIDTH  number of completed tile loads.
- tiles_executed  out  TILE_CNT_WIDTH  number of accepted ex_tile_done pulses.
- err_underflow  out  1  sticky error flag.

Behaviour:
- Reset is synchronous and active-high. At the first edge with rst=1, all of the following clear to 0:
  - load pointer lp, exec pointer ep, word counter wcnt, full[1:0];
  - all counters and err_underflow;
  - buf_ld_wr_en, buf_ld_sel, buf_ld_addr, buf_ld_data.
- While rst=1, ld_ready=0. The cycle after rst falls, ld_ready=1.
- ld_ready = !full[lp] && !rst, combinational from registered state.
- A beat is accepted when ld_valid && ld_ready. In cycle t:
  - if wcnt==0, cfg_ld_len is captured into len_r and held for the whole tile; changes to cfg_ld_len mid-tile are ignored;
  - at t+1, registered outputs show buf_ld_wr_en=1, buf_ld_sel=lp(t), buf_ld_addr=wcnt(t), buf_ld_data=ld_data(t). Write latency is exactly one cycle;
  - when there is no accepted beat, buf_ld_wr_en=0 in the next cycle.
- Last beat: the beat with wcnt==len_r (or wcnt==cfg_ld_len when wcnt==0).
  - Effective at t+1: wcnt←0 and lp toggles.
  - Effective at t+2: full[lp_old]←1 and tiles_loaded increments.
  - The flag is set with the same edge that commits the final write, so ex_tile_valid never rises before the tile data is in memory.
  - Any other accepted beat gives wcnt←wcnt+1.
- Tile length range is 1..2^BUF_LD_ADDR_WIDTH words. cfg_ld_len=0 gives a 1-word tile, which is legal.
- Back-to-back tiles: if the other bank is empty, ld_ready stays 1 across the tile boundary with no bubble.
- Executor side:
  - buf_ex_sel = ep and ex_tile_valid = full[ep], both combinational from registers.
  - ex_tile_done with full[ep]=1: next cycle full[ep]=0, ep toggles, tiles_executed increments.
  - ex_tile_done with full[ep]=0: ignored for all state, and err_underflow←1. err_underflow clears only on rst.
- Simultaneous events:
  - A full-set on one bank and ex_tile_done clearing the other bank in the same cycle: both apply.
  - Set and clear cannot target the same bank in the same cycle, because a clear requires the bank to be full and a set requires it to be non-full while loading.
- Both banks full: ld_ready=0. The loader holds ld_valid and ld_data until ready returns.
- Counters wrap modulo 2^TILE_CNT_WIDTH.
- Reset mid-tile: the partially loaded tile is discarded and not marked full; the next tile starts at bank 0, address 0.

Test Plan:
- Reset: hold rst=1 for 3 cycles with ld_valid=1 → ld_ready=0 and all outputs 0 during reset; ld_ready=1 on the first cycle after rst falls.
- Single tile: cfg_ld_len=3; stream data 0xA0..0xA3 on consecutive cycles → buf_ld_wr_en=1 for 4 cycles with addr 0,1,2,3, sel=0, data A0..A3, each one cycle after acceptance; ex_tile_valid=1 and buf_ex_sel=0 two cycles after the last accept; tiles_loaded=1.
- Backpressure: cfg_ld_len=3, stream 8 beats with no ex_tile_done → bank_full=2'b11 and ld_ready=0; the 9th beat stalls with data held. Pulse ex_tile_done → bank_full=2'b10, buf_ex_sel=1, ld_ready=1 next cycle; the 9th beat is written to sel=0, addr=0.
- Underflow: with bank_full=0, pulse ex_tile_done → err_underflow=1 and stays 1; ep, full and tiles_executed unchanged.
- Simultaneous events: the last beat of bank 1 and ex_tile_done for bank 0 occur in the same cycle → bank 0 clears and bank 1 sets; final bank_full=2'b10, buf_ex_sel=1.
- Reset mid-tile: cfg_ld_len=7; accept 3 beats, assert rst for 1 cycle, then stream 8 beats → first write after reset at sel=0, addr=0; bank_full=2'b01 after the 8th beat.
